// File: rtl/sevenseg_scan_if.sv
// Bus between game logic and the 7-segment scan controller.
// The controller connects to the slave side; the source of values takes the master side.
interface sevenseg_scan_if;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  en_mask;
    logic [3:0]  dp_in;
    logic [3:0]  nibble;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;
    logic        committed;

    modport master (
        output value_in, load, en_mask, dp_in,
        input  nibble, an, dp, frame_tick, committed
    );

    modport slave (
        input  value_in, load, en_mask, dp_in,
        output nibble, an, dp, frame_tick, committed
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Four-digit common-anode scan controller with frame-synchronous value commit and dead time.
// Define SEVENSEG_LZB_EN to blank leading zero digits (digit 0 always shown).
module sevenseg_scan_ctrl #(
    parameter int PRESCALE    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           reset,
    sevenseg_scan_if.slave bus
);
    localparam int MAXC = (PRESCALE > DEAD_CYCLES) ? PRESCALE : DEAD_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] ON_LAST   = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

    typedef enum logic {ST_DEAD, ST_ON} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   staging_q, staging_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [3:0]    an_q, an_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          dp_q, dp_d;
    logic          frame_tick_q, frame_tick_d;
    logic          committed_q, committed_d;
    logic          blank, lit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        staging_d    = staging_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_tick_d = 1'b0;
        committed_d  = 1'b0;
        blank        = 1'b0;

        case (state_q)
            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d        = '0;
                    idx_d        = idx_q + 2'd1;
                    state_d      = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
                    frame_tick_d = (idx_q == 2'd3);
                end
            end
        endcase

        // A load landing exactly on the frame edge skips staging so it is not delayed a frame.
        if (frame_tick_d && bus.load) begin
            shadow_d    = bus.value_in;
            staging_d   = bus.value_in;
            pending_d   = 1'b0;
            committed_d = 1'b1;
        end else if (frame_tick_d && pending_q) begin
            shadow_d    = staging_q;
            pending_d   = 1'b0;
            committed_d = 1'b1;
        end else if (bus.load) begin
            staging_d = bus.value_in;
            pending_d = 1'b1;
        end

`ifdef SEVENSEG_LZB_EN
        case (idx_d)
            2'd3:    blank = (shadow_d[15:12] == 4'h0);
            2'd2:    blank = (shadow_d[15:8]  == 8'h0);
            2'd1:    blank = (shadow_d[15:4]  == 12'h0);
            default: blank = 1'b0;
        endcase
`endif

        lit      = (state_d == ST_ON) && bus.en_mask[idx_d] && !blank;
        an_d     = lit ? ~(4'b0001 << idx_d) : 4'hF;
        dp_d     = ~(lit & bus.dp_in[idx_d]);
        nibble_d = shadow_d[{idx_d, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_DEAD;
            cnt_q        <= '0;
            idx_q        <= '0;
            staging_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= 4'hF;
            nibble_q     <= 4'h0;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
            committed_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            nibble_q     <= nibble_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
            committed_q  <= committed_d;
        end
    end

    assign bus.an         = an_q;
    assign bus.nibble     = nibble_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.committed  = committed_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench: DUT A (PRESCALE=4, DEAD=2) and DUT B (PRESCALE=4, DEAD=0) checked every cycle
// against hand-derived slot timing; expectations follow SEVENSEG_LZB_EN when defined.
module tb_sevenseg_scan_ctrl;
`ifdef SEVENSEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   run;
    logic [15:0] exp_sh;

    sevenseg_scan_if ifa ();
    sevenseg_scan_if ifb ();

    sevenseg_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(2)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    sevenseg_scan_ctrl #(.PRESCALE(4), .DEAD_CYCLES(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic lzb_blank(input logic [15:0] sh, input int slot);
        return LZB && (slot != 0) && ((sh >> (4 * slot)) == 16'h0);
    endfunction

    task automatic check_cycle(input int c);
        int pos, slot, bslot;
        logic on, lit, blit, exp_commit;
        logic [3:0] mask, dpi, exp_an, exp_bn;

        if (run == 1 && c == 48)  exp_sh = 16'hA3F0;
        if (run == 1 && c == 72)  exp_sh = 16'h1234;
        if (run == 1 && c == 120) exp_sh = 16'h2222;
        if (run == 2 && c == 48)  exp_sh = 16'h0070;
        exp_commit = (run == 1 && (c == 48 || c == 72 || c == 120)) || (run == 2 && c == 48);
        mask = (run == 1 && c >= 144) ? 4'b0101 : 4'b1111;
        dpi  = (run == 1 && c >= 144) ? 4'b1111 : 4'b0000;

        // DUT A: 24-cycle frame, each 6-cycle slot is 2 dark then 4 lit
        pos  = c % 24;
        slot = pos / 6;
        on   = (pos % 6) >= 2;
        lit  = on && mask[slot] && !lzb_blank(exp_sh, slot);
        exp_an = lit ? ~(4'b0001 << slot) : 4'hF;
        chk("a_an", 16'(ifa.an), 16'(exp_an));
        chk("a_dp", 16'(ifa.dp), 16'(!(lit && dpi[slot])));
        chk("a_tick", 16'(ifa.frame_tick), 16'(c > 0 && pos == 0));
        chk("a_commit", 16'(ifa.committed), 16'(exp_commit));
        if (on) chk("a_nibble", 16'(ifa.nibble), 16'((exp_sh >> (4 * slot)) & 16'hF));
        chk("a_1hot", 16'($countones(~ifa.an) <= 1), 16'd1);

        // DUT B: one dark cycle after reset, then back-to-back 4-cycle slots
        bslot = (c == 0) ? 0 : ((c - 1) % 16) / 4;
        blit  = (c != 0) && !lzb_blank(16'h0, bslot);
        exp_bn = blit ? ~(4'b0001 << bslot) : 4'hF;
        chk("b_an", 16'(ifb.an), 16'(exp_bn));
        chk("b_tick", 16'(ifb.frame_tick), 16'(c > 1 && ((c - 1) % 16) == 0));
        chk("b_1hot", 16'($countones(~ifb.an) <= 1), 16'd1);
    endtask

    task automatic drive(input int c);
        ifa.load = 1'b0;
        if (run == 1) begin
            case (c)
                30:  begin ifa.load = 1'b1; ifa.value_in = 16'hA3F0; end
                71:  begin ifa.load = 1'b1; ifa.value_in = 16'h1234; end
                100: begin ifa.load = 1'b1; ifa.value_in = 16'h1111; end
                105: begin ifa.load = 1'b1; ifa.value_in = 16'h2222; end
                143: begin ifa.en_mask = 4'b0101; ifa.dp_in = 4'b1111; end
                200: begin ifa.load = 1'b1; ifa.value_in = 16'h5555; end
                206: begin reset = 1'b1; ifa.en_mask = 4'b1111; ifa.dp_in = 4'b0000; end
                default: ;
            endcase
        end else if (c == 30) begin
            ifa.load = 1'b1;
            ifa.value_in = 16'h0070;
        end
    endtask

    initial begin
        reset = 1'b1;
        ifa.value_in = '0; ifa.load = 1'b0; ifa.en_mask = 4'b1111; ifa.dp_in = 4'b0000;
        ifb.value_in = '0; ifb.load = 1'b0; ifb.en_mask = 4'b1111; ifb.dp_in = 4'b0000;
        exp_sh = '0;
        run = 1;

        tick();
        tick();
        chk("rst_an", 16'(ifa.an), 16'hF);
        chk("rst_dp", 16'(ifa.dp), 16'd1);
        chk("rst_nibble", 16'(ifa.nibble), 16'd0);
        chk("rst_tick", 16'(ifa.frame_tick), 16'd0);
        chk("rst_commit", 16'(ifa.committed), 16'd0);
        chk("rst_b_an", 16'(ifb.an), 16'hF);
        reset = 1'b0;

        for (int c = 0; c <= 206; c++) begin
            check_cycle(c);
            drive(c);
            tick();
        end

        // reset landed during digit 2 ON with a load still pending
        chk("mid_rst_an", 16'(ifa.an), 16'hF);
        chk("mid_rst_nibble", 16'(ifa.nibble), 16'd0);
        reset = 1'b0;
        run = 2;
        exp_sh = '0;
        for (int c = 0; c <= 71; c++) begin
            check_cycle(c);
            drive(c);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
- Time-multiplexes four hex digits of a 16-bit value onto the board's 4-digit common-anode display.
- Drives one shared hex7seg decoder: this block supplies the nibble and the active-low anodes; the decoder supplies the segments.
- Frame-synchronous value update prevents digit tearing.
- Programmable dead time between digits suppresses ghosting.
- Sits between game logic (score/attempt counter) and the display pins.

Parameters:
- PRESCALE, 100000, clk cycles each digit is lit (1 kHz per digit at 100 MHz); must be >= 1.
- DEAD_CYCLES, 1000, clk cycles with all anodes off between digits; 0 = no dead state.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- value_in  input  16  value to display; digit 0 = value_in[3:0] (rightmost).
- load  input  1  one-cycle strobe; captures value_in into the staging register.
- en_mask  input  4  per-digit enable; 0 = digit dark during its slot.
- dp_in  input  4  per-digit decimal point, active high.
- nibble  output  4  hex digit to the hex7seg decoder input.
- an  output  4  anodes, active low, at most one low.
- dp  output  1  decimal point, active low.
- frame_tick  output  1  one-cycle pulse at each frame start (digit 3 -> 0 wrap).
- committed  output  1  one-cycle pulse when staging is copied to the shadow register.

Behaviour:
- Reset values:
  - an=4'b1111, dp=1, nibble=0, frame_tick=0, committed=0.
  - Staging=0, shadow=0, pending=0, idx=0, counter=0, state=DEAD.
- State DEAD:
  - an=1111, dp=1.
  - Counts DEAD_CYCLES cycles, then enters ON for the current idx.
  - With DEAD_CYCLES=0, DEAD is skipped: ON goes directly to the next ON.
- State ON:
  - Lasts exactly PRESCALE cycles, then goes to DEAD and idx increments mod 4.
  - an[idx]=0 only if en_mask[idx]=1; otherwise an=1111.
  - nibble = shadow[4*idx+3 : 4*idx].
  - dp = ~(dp_in[idx] & en_mask[idx]).
- Outputs are registered and change on the same edge the state enters ON or DEAD.
- Slot period is PRESCALE+DEAD_CYCLES; frame period is 4x that. Disabled digits keep their slot time, so the frame rate is constant.
- Frame start:
  - Defined as the edge where idx wraps 3->0 (the counter transition into digit 0's DEAD, or into ON when DEAD_CYCLES=0).
  - frame_tick pulses high for one cycle on that edge.
  - If pending=1: shadow<=staging, pending<=0, committed pulses in the same cycle as frame_tick.
- load:
  - Sets staging<=value_in and pending<=1.
  - Multiple loads within a frame: the last one wins; only one commit occurs.
- load on the frame-start edge:
  - value_in bypasses staging and commits immediately; committed pulses.
  - pending ends at 0.
- en_mask and dp_in are sampled live each ON cycle (not shadowed).
- Counter width is $clog2(max(PRESCALE, DEAD_CYCLES))+1; the counter never wraps mid-slot.
- reset asserted mid-slot: the next edge returns everything to reset values, including dropping a pending load. The display restarts at digit 0 after DEAD_CYCLES.
- Invariant: an never has more than one bit low, and no cycle has two different digits lit.

Optional Feature:
- Macro: SEVENSEG_LZB_EN (leading-zero blanking).
- With macro defined:
  - Digit k (k=3..1) is additionally blanked (an bit high, dp high) when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked by this rule.
  - Blanking is evaluated from the shadow register, so it changes only at frame start.
- Without macro: all enabled digits are shown, including leading zeros.

Test Plan:
- Reset/sequence (PRESCALE=4, DEAD_CYCLES=2, en_mask=1111, shadow=0):
  - During reset: an=1111.
  - After release: 2 cycles of an=1111, then an=1110 for 4 cycles, 2 dark, an=1101 ...
  - frame_tick every 24 cycles.
- Commit timing:
  - load with value_in=16'hA3F0 mid-frame -> nibble/an unchanged until the next frame_tick.
  - committed pulses with frame_tick; next frame shows nibble 0,F,3,A for idx 0..3.
- Coincident load:
  - load 16'h1234 on the frame-start edge -> committed=1 that cycle, pending=0.
  - Digit 0 shows 4 in that frame.
  - Two loads in one frame (16'h1111 then 16'h2222) -> one commit, 2222 displayed.
- Mask/dp:
  - en_mask=0101, dp_in=1111 -> an bits 1 and 3 never low; frame period still 24 cycles.
  - dp=0 only in slots 0 and 2.
- DEAD_CYCLES=0 -> consecutive ON slots back-to-back; an never 1111 after the first slot.
  - Check an is one-hot-low on every cycle.
- Reset mid-operation and LZB:
  - reset during digit 2 ON with pending load -> next cycle an=1111, shadow=0, load discarded.
  - With SEVENSEG_LZB_EN and value 16'h0070: digits 3 and 2 dark, digits 1 and 0 show 7 and 0.
  - With value 0: only digit 0 lit, showing 0.
